spi_rdid_responder: RTL and testbench

- SPI mode-0 target that emulates the JEDEC Read-ID (RDID) response of a serial flash, so the SPI master can be exercised in simulation and on-board without a real flash part.
- Oversamples the SPI pins in the system clock domain and captures an 8-bit opcode MSB-first.
- On opcode 0x9F, shifts out a 24-bit ID (manufacturer, memory type, capacity) MSB-first on MISO. Any other opcode is reported and otherwise ignored.

---
 rtl/spi_rdid_responder.sv | 179 +++++++++++++++++
 tb/tb_spi_rdid_responder.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/spi_rdid_responder.sv
// SPI mode-0 target that answers the JEDEC Read-ID opcode with a fixed 24-bit ID.
// Latency: pin edges act 2-3 clk later (2-flop sync + edge detect, registered outputs).
// Backpressure: none; the SPI master sets the pace, and SCK high/low must each last >= 4 clk.
module spi_rdid_responder #(
  parameter logic [7:0] RDID_OPCODE     = 8'h9F,
  parameter logic [7:0] MANUFACTURE_ID  = 8'hEF,
  parameter logic [7:0] MEMORY_TYPE     = 8'h40,
  parameter logic [7:0] MEMORY_CAPACITY = 8'h18
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       spi_clk,
  input  logic       spi_cs_n,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic       spi_miso_oe,
  output logic [7:0] cmd_byte,
  output logic       cmd_valid,
  output logic       rdid_done,
  output logic       frame_abort
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_RESP,
    ST_IGNORE,
    ST_DONE
  } state_t;

  // Bit 0 = sync stage 1, bit 1 = stage 2, bit 2 = history flop for edge detection.
  logic [2:0]  sck_q, sck_d;
  logic [2:0]  cs_q, cs_d;
  logic [1:0]  mosi_q, mosi_d;

  state_t      state_q, state_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [4:0]  out_cnt_q, out_cnt_d;
  logic [7:0]  shift_in_q, shift_in_d;
  logic [23:0] id_shift_q, id_shift_d;
  logic        miso_q, miso_d;
  logic        oe_q, oe_d;
  logic [7:0]  cmd_byte_q, cmd_byte_d;
  logic        cmd_valid_q, cmd_valid_d;
  logic        rdid_done_q, rdid_done_d;
  logic        frame_abort_q, frame_abort_d;

  logic        sck_rise, sck_fall, cs_rise, cs_fall;
  logic [7:0]  byte_next;

  assign sck_rise  = sck_q[1] & ~sck_q[2];
  assign sck_fall  = ~sck_q[1] & sck_q[2];
  assign cs_rise   = cs_q[1] & ~cs_q[2];
  assign cs_fall   = ~cs_q[1] & cs_q[2];
  assign byte_next = {shift_in_q[6:0], mosi_q[1]};

  // Next-state logic: synchronizers, frame FSM, shift registers and one-clk pulses.
  always_comb begin
    sck_d         = {sck_q[1:0], spi_clk};
    cs_d          = {cs_q[1:0], spi_cs_n};
    mosi_d        = {mosi_q[0], spi_mosi};
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    out_cnt_d     = out_cnt_q;
    shift_in_d    = shift_in_q;
    id_shift_d    = id_shift_q;
    miso_d        = miso_q;
    oe_d          = oe_q;
    cmd_byte_d    = cmd_byte_q;
    cmd_valid_d   = 1'b0;
    rdid_done_d   = 1'b0;
    frame_abort_d = 1'b0;

    if (cs_rise) begin
      // Deselect wins over any SCK edge seen in the same cycle.
      if (state_q != ST_IDLE) begin
        frame_abort_d = (state_q == ST_RESP) ||
                        ((state_q == ST_CMD) && (bit_cnt_q != 4'd0));
        state_d       = ST_IDLE;
        miso_d        = 1'b0;
        oe_d          = 1'b0;
      end
    end else if (cs_fall) begin
      // Every new frame starts from scratch; only cmd_byte survives.
      state_d    = ST_CMD;
      bit_cnt_d  = 4'd0;
      out_cnt_d  = 5'd0;
      shift_in_d = 8'h00;
      id_shift_d = 24'h0;
      miso_d     = 1'b0;
      oe_d       = 1'b1;
    end else begin
      case (state_q)
        ST_CMD: begin
          if (sck_rise) begin
            shift_in_d = byte_next;
            if (bit_cnt_q != 4'hF) bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              cmd_byte_d  = byte_next;
              cmd_valid_d = 1'b1;
              if (byte_next == RDID_OPCODE) begin
                state_d    = ST_RESP;
                id_shift_d = {MANUFACTURE_ID, MEMORY_TYPE, MEMORY_CAPACITY};
                out_cnt_d  = 5'd0;
              end else begin
                state_d = ST_IGNORE;
              end
            end
          end
        end
        ST_RESP: begin
          // Launch on fall so the bit is stable before the master samples on rise.
          if (sck_fall) begin
            miso_d     = id_shift_q[23];
            id_shift_d = {id_shift_q[22:0], 1'b0};
          end
          if (sck_rise) begin
            if (out_cnt_q != 5'd31) out_cnt_d = out_cnt_q + 5'd1;
            if (out_cnt_q == 5'd23) begin
              rdid_done_d = 1'b1;
              state_d     = ST_DONE;
              miso_d      = 1'b0;
            end
          end
        end
        ST_IGNORE, ST_DONE: begin
          miso_d = 1'b0;
          oe_d   = 1'b1;
        end
        default: begin
          oe_d = 1'b0;
        end
      endcase
    end
  end

  // State register with synchronous active-low reset to idle pin levels.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sck_q         <= 3'b000;
      cs_q          <= 3'b111;
      mosi_q        <= 2'b00;
      state_q       <= ST_IDLE;
      bit_cnt_q     <= 4'd0;
      out_cnt_q     <= 5'd0;
      shift_in_q    <= 8'h00;
      id_shift_q    <= 24'h0;
      miso_q        <= 1'b0;
      oe_q          <= 1'b0;
      cmd_byte_q    <= 8'h00;
      cmd_valid_q   <= 1'b0;
      rdid_done_q   <= 1'b0;
      frame_abort_q <= 1'b0;
    end else begin
      sck_q         <= sck_d;
      cs_q          <= cs_d;
      mosi_q        <= mosi_d;
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      out_cnt_q     <= out_cnt_d;
      shift_in_q    <= shift_in_d;
      id_shift_q    <= id_shift_d;
      miso_q        <= miso_d;
      oe_q          <= oe_d;
      cmd_byte_q    <= cmd_byte_d;
      cmd_valid_q   <= cmd_valid_d;
      rdid_done_q   <= rdid_done_d;
      frame_abort_q <= frame_abort_d;
    end
  end

  assign spi_miso    = miso_q;
  assign spi_miso_oe = oe_q;
  assign cmd_byte    = cmd_byte_q;
  assign cmd_valid   = cmd_valid_q;
  assign rdid_done   = rdid_done_q;
  assign frame_abort = frame_abort_q;

endmodule

// File: tb/tb_spi_rdid_responder.sv
// Bench for spi_rdid_responder: randomized SPI frames against a frame-level reference model.
// Expected pulses are queued per frame; a negedge monitor pops and compares them.
// MISO bits are checked by the bench's SPI master just before each SCK rise.
module tb_spi_rdid_responder;

  localparam logic [7:0]  OP_RDID = 8'h9F;
  localparam logic [23:0] ID_EXP  = 24'hEF4018;

  localparam logic [1:0] EV_CMD   = 2'd0;
  localparam logic [1:0] EV_DONE  = 2'd1;
  localparam logic [1:0] EV_ABORT = 2'd2;

  typedef struct packed {
    logic [1:0] kind;
    logic [7:0] dat;
  } evt_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       spi_clk = 1'b0;
  logic       spi_cs_n = 1'b1;
  logic       spi_mosi = 1'b0;
  logic       spi_miso;
  logic       spi_miso_oe;
  logic [7:0] cmd_byte;
  logic       cmd_valid;
  logic       rdid_done;
  logic       frame_abort;

  int   checks = 0;
  int   errors = 0;
  evt_t exp_q[$];

  spi_rdid_responder dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .spi_clk     (spi_clk),
    .spi_cs_n    (spi_cs_n),
    .spi_mosi    (spi_mosi),
    .spi_miso    (spi_miso),
    .spi_miso_oe (spi_miso_oe),
    .cmd_byte    (cmd_byte),
    .cmd_valid   (cmd_valid),
    .rdid_done   (rdid_done),
    .frame_abort (frame_abort)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_evt(input logic [1:0] kind, input logic [7:0] dat);
    evt_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_event: got kind %0d (data %0h) expected none at %0t", kind, dat, $time);
    end else begin
      e = exp_q.pop_front();
      check("event_kind", 32'(kind), 32'(e.kind));
      if (e.kind == EV_CMD && kind == EV_CMD) check("cmd_byte", 32'(dat), 32'(e.dat));
    end
  endtask

  // Monitor: every output pulse must match the next expected event.
  always @(negedge clk) begin
    if (cmd_valid)   check_evt(EV_CMD, cmd_byte);
    if (rdid_done)   check_evt(EV_DONE, 8'h00);
    if (frame_abort) check_evt(EV_ABORT, 8'h00);
  end

  // Advance n clocks and land away from the active edge.
  task automatic wclk(input int n);
    if (n > 0) repeat (n) @(posedge clk);
    #3;
  endtask

  // One SPI frame of n SCK cycles; ends with CS rise (or a reset when rst_end).
  task automatic frame(input logic [7:0] op, input int n, input bit rst_end, input int gap);
    evt_t e;
    logic exp_bit;
    int   half;
    // Reference model: what the frame should report.
    if (n > 0 && n < 8 && !rst_end) begin
      e.kind = EV_ABORT; e.dat = 8'h00; exp_q.push_back(e);
    end
    if (n >= 8) begin
      e.kind = EV_CMD; e.dat = op; exp_q.push_back(e);
      if (op == OP_RDID) begin
        if (n >= 32) begin
          e.kind = EV_DONE; e.dat = 8'h00; exp_q.push_back(e);
        end else if (!rst_end) begin
          e.kind = EV_ABORT; e.dat = 8'h00; exp_q.push_back(e);
        end
      end
    end

    spi_cs_n = 1'b0;
    wclk($urandom_range(5, 7));
    check("oe_selected", 32'(spi_miso_oe), 32'd1);
    for (int i = 0; i < n; i++) begin
      half = $urandom_range(5, 8);
      spi_mosi = (i < 8) ? op[7-i] : 1'($urandom);
      wclk(half);
      // Bit i of the frame: opcode phase reads 0, then the ID MSB-first, then 0.
      exp_bit = (op == OP_RDID && i >= 8 && i < 32) ? ID_EXP[31-i] : 1'b0;
      check("miso_bit", 32'(spi_miso), 32'(exp_bit));
      spi_clk = 1'b1;
      wclk(half);
      spi_clk = 1'b0;
    end
    wclk($urandom_range(5, 8));

    if (rst_end) begin
      reset_n = 1'b0;
      wclk(1);
      spi_cs_n = 1'b1;
      wclk(1);
      check("rst_oe", 32'(spi_miso_oe), 32'd0);
      check("rst_miso", 32'(spi_miso), 32'd0);
      check("rst_cmd_byte", 32'(cmd_byte), 32'h00);
      reset_n = 1'b1;
      wclk(4);
    end else begin
      spi_cs_n = 1'b1;
      wclk(4);
      check("oe_deselected", 32'(spi_miso_oe), 32'd0);
      check("miso_deselected", 32'(spi_miso), 32'd0);
      if (gap > 4) wclk(gap - 4);
    end
    check("events_pending", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] op;
    reset_n = 1'b0;
    wclk(3);
    check("reset_oe", 32'(spi_miso_oe), 32'd0);
    check("reset_miso", 32'(spi_miso), 32'd0);
    check("reset_cmd_byte", 32'(cmd_byte), 32'h00);
    check("reset_pulses", 32'({cmd_valid, rdid_done, frame_abort}), 32'd0);
    reset_n = 1'b1;
    wclk(4);

    frame(OP_RDID, 32, 1'b0, 6);  // full RDID
    frame(8'h05, 24, 1'b0, 6);    // other opcode
    frame(OP_RDID, 4, 1'b0, 6);   // abort in opcode
    frame(OP_RDID, 32, 1'b0, 6);
    frame(OP_RDID, 20, 1'b0, 6);  // abort after 12 response bits
    frame(OP_RDID, 32, 1'b0, 6);
    frame(OP_RDID, 18, 1'b1, 0);  // reset after 10 response bits
    frame(OP_RDID, 32, 1'b0, 6);
    frame(OP_RDID, 40, 1'b0, 4);  // over-clocked, then back-to-back
    frame(OP_RDID, 32, 1'b0, 4);
    frame(OP_RDID, 32, 1'b0, 6);
    frame(OP_RDID, 8, 1'b0, 6);   // deselect right after opcode
    frame(8'h05, 8, 1'b0, 6);
    frame(8'h00, 0, 1'b0, 6);     // select with no clocks

    for (int k = 0; k < 20; k++) begin
      op = ($urandom_range(0, 1) == 1) ? OP_RDID : 8'($urandom);
      frame(op, $urandom_range(0, 36), 1'b0, $urandom_range(4, 8));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
